// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter: count controls in, count state out.
// The counter drives the slave side; a controller or bench drives the master side.
interface mod_updown_counter_if #(
  parameter int unsigned N = 8
);
  logic         cin;
  logic         up;
  logic         load;
  logic [N-1:0] d;
  logic [N-1:0] cmp;
  logic         clr_ovf;
  logic [N-1:0] q;
  logic         cout;
  logic         bout;
  logic         match;
  logic         ovf;

  modport master (
    output cin, up, load, d, cmp, clr_ovf,
    input  q, cout, bout, match, ovf
  );

  modport slave (
    input  cin, up, load, d, cmp, clr_ovf,
    output q, cout, bout, match, ovf
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with parallel load, wrap/saturate limits, compare match
// and a sticky limit-event flag; cascadable through cout/bout into the next cin.
module mod_updown_counter #(
  parameter int unsigned N        = 8,
  parameter int unsigned MODULUS  = 256,
  parameter bit          SATURATE = 1'b0
) (
  input logic              clk,
  input logic              reset,
  mod_updown_counter_if.slave bus
);
  localparam int unsigned W = N + 1;
  localparam logic [N:0]  LIM = W'(MODULUS - 1);

  generate
    if (MODULUS < 2 || longint'(MODULUS) > (64'd1 << N)) begin : g_bad_modulus
      $error("mod_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**N");
    end
  endgenerate

  logic [N-1:0] q_r;
  logic         match_r;
  logic         ovf_r;
  logic [N:0]   q_ext;
  logic [N:0]   d_ext;
  logic [N:0]   q_nxt;
  logic         at_max;
  logic         at_zero;
  logic         cnt_en;
  logic         limit_evt;

  // One extra bit so MODULUS = 2**N still compares against its full limit.
  assign q_ext   = {1'b0, q_r};
  assign d_ext   = {1'b0, bus.d};
  assign at_max  = (q_ext == LIM);
  assign at_zero = (q_r == '0);

  assign cnt_en    = bus.cin & ~bus.load;
  assign limit_evt = cnt_en & ~reset & ((bus.up & at_max) | (~bus.up & at_zero));

  assign bus.cout  = cnt_en &  bus.up & at_max;
  assign bus.bout  = cnt_en & ~bus.up & at_zero;
  assign bus.q     = q_r;
  assign bus.match = match_r;
  assign bus.ovf   = ovf_r;

  always_comb begin
    q_nxt = q_ext;
    if (bus.load) begin
      q_nxt = (d_ext > LIM) ? LIM : d_ext;
    end else if (bus.cin) begin
      if (bus.up) begin
        if (!at_max)        q_nxt = q_ext + W'(1);
        else if (!SATURATE) q_nxt = '0;
      end else begin
        if (!at_zero)       q_nxt = q_ext - W'(1);
        else if (!SATURATE) q_nxt = LIM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r     <= '0;
      match_r <= (bus.cmp == '0);
      ovf_r   <= 1'b0;
    end else begin
      q_r     <= q_nxt[N-1:0];
      match_r <= (q_nxt == {1'b0, bus.cmp});
      // A limit event in the same cycle as clr_ovf keeps the flag set.
      if (limit_evt)        ovf_r <= 1'b1;
      else if (bus.clr_ovf) ovf_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench: wrap, saturate and 2**N-modulus counters share one stimulus stream, plus a
// two-digit BCD cascade; all checked against arithmetic models of the count rules.
module tb_mod_updown_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, load, cin, up, clr_ovf;
    logic [3:0] d4, cmp4;
    logic [7:0] d8, cmp8;
    logic       c_reset, c_cin, c_up;

    mod_updown_counter_if #(.N(4)) ia ();
    mod_updown_counter_if #(.N(4)) ib ();
    mod_updown_counter_if #(.N(8)) iw ();
    mod_updown_counter_if #(.N(4)) ilo ();
    mod_updown_counter_if #(.N(4)) ihi ();

    assign ia.cin = cin;  assign ia.up = up;  assign ia.load = load;
    assign ia.d = d4;     assign ia.cmp = cmp4; assign ia.clr_ovf = clr_ovf;
    assign ib.cin = cin;  assign ib.up = up;  assign ib.load = load;
    assign ib.d = d4;     assign ib.cmp = cmp4; assign ib.clr_ovf = clr_ovf;
    assign iw.cin = cin;  assign iw.up = up;  assign iw.load = load;
    assign iw.d = d8;     assign iw.cmp = cmp8; assign iw.clr_ovf = clr_ovf;

    assign ilo.cin = c_cin; assign ilo.up = c_up; assign ilo.load = 1'b0;
    assign ilo.d = '0;      assign ilo.cmp = '0;  assign ilo.clr_ovf = 1'b0;
    assign ihi.cin = ilo.cout | ilo.bout;
    assign ihi.up = c_up;   assign ihi.load = 1'b0;
    assign ihi.d = '0;      assign ihi.cmp = '0;  assign ihi.clr_ovf = 1'b0;

    mod_updown_counter #(.N(4), .MODULUS(10),  .SATURATE(1'b0)) u_wrap (.clk(clk), .reset(reset),   .bus(ia));
    mod_updown_counter #(.N(4), .MODULUS(10),  .SATURATE(1'b1)) u_sat  (.clk(clk), .reset(reset),   .bus(ib));
    mod_updown_counter #(.N(8), .MODULUS(256), .SATURATE(1'b0)) u_wide (.clk(clk), .reset(reset),   .bus(iw));
    mod_updown_counter #(.N(4), .MODULUS(10),  .SATURATE(1'b0)) u_lo   (.clk(clk), .reset(c_reset), .bus(ilo));
    mod_updown_counter #(.N(4), .MODULUS(10),  .SATURATE(1'b0)) u_hi   (.clk(clk), .reset(c_reset), .bus(ihi));

    int unsigned passed = 0;
    int unsigned total  = 0;

    // Reference state: per single counter, and the cascade as one 0..99 value.
    int mod_v [3] = '{10, 10, 256};
    bit sat_v [3] = '{1'b0, 1'b1, 1'b0};
    int mq [3];
    bit movf [3];
    bit mmatch [3];
    int cval;
    int pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input bit r, input bit l, input bit c, input bit u, input bit clr,
                         input int dv, input int cv);
        reset = r; load = l; cin = c; up = u; clr_ovf = clr;
        d4 = 4'(dv); cmp4 = 4'(cv); d8 = 8'(dv); cmp8 = 8'(cv);
    endtask

    task automatic tick();
        logic [7:0] oq [3];
        logic oc [3], ob [3], om [3], oo [3];
        int dv, cv, nq;
        bit past;
        #2;
        oc = '{ia.cout, ib.cout, iw.cout};
        ob = '{ia.bout, ib.bout, iw.bout};
        for (int i = 0; i < 3; i++) begin
            dv = (i == 2) ? int'(d8) : int'(d4);
            cv = (i == 2) ? int'(cmp8) : int'(cmp4);
            check($sformatf("cout%0d", i), oc[i], cin && up && !load && mq[i] == mod_v[i] - 1);
            check($sformatf("bout%0d", i), ob[i], cin && !up && !load && mq[i] == 0);
            past = up ? (mq[i] + 1 >= mod_v[i]) : (mq[i] - 1 < 0);
            if (up) nq = sat_v[i] ? ((mq[i] + 1 < mod_v[i]) ? mq[i] + 1 : mod_v[i] - 1)
                                  : (mq[i] + 1) % mod_v[i];
            else    nq = sat_v[i] ? ((mq[i] > 0) ? mq[i] - 1 : 0)
                                  : (mq[i] + mod_v[i] - 1) % mod_v[i];
            if (reset) begin
                mq[i] = 0; movf[i] = 1'b0;
            end else if (load) begin
                mq[i] = (dv < mod_v[i]) ? dv : mod_v[i] - 1;
                if (clr_ovf) movf[i] = 1'b0;
            end else begin
                if (cin) mq[i] = nq;
                if (cin && past) movf[i] = 1'b1;
                else if (clr_ovf) movf[i] = 1'b0;
            end
            mmatch[i] = (mq[i] == cv);
        end
        check("casc_cout_lo", ilo.cout, c_cin && c_up && cval % 10 == 9);
        check("casc_cout_hi", ihi.cout, c_cin && c_up && cval == 99);
        check("casc_bout_hi", ihi.bout, c_cin && !c_up && cval == 0);
        pulses += int'(ihi.cout);
        if (c_reset) cval = 0;
        else if (c_cin) cval = c_up ? (cval + 1) % 100 : (cval + 99) % 100;
        @(posedge clk);
        #1;
        oq = '{8'(ia.q), 8'(ib.q), iw.q};
        om = '{ia.match, ib.match, iw.match};
        oo = '{ia.ovf, ib.ovf, iw.ovf};
        for (int i = 0; i < 3; i++) begin
            check($sformatf("q%0d", i), oq[i], mq[i]);
            check($sformatf("match%0d", i), om[i], mmatch[i]);
            check($sformatf("ovf%0d", i), oo[i], movf[i]);
        end
        check("casc_q_lo", ilo.q, cval % 10);
        check("casc_q_hi", ihi.q, cval / 10);
    endtask

    initial begin
        mq = '{0, 0, 0}; movf = '{0, 0, 0}; mmatch = '{0, 0, 0};
        cval = 0; pulses = 0;
        c_reset = 1'b1; c_cin = 1'b0; c_up = 1'b1;

        drive(1, 0, 0, 1, 0, 0, 0); tick();
        check("reset_match", ia.match, 1'b1);
        // Reset overrides a simultaneous load.
        drive(0, 1, 0, 1, 0, 7, 0); tick();
        drive(1, 1, 1, 1, 0, 3, 0); tick();
        check("reset_over_load", ia.q, 4'd0);
        // Wrap/saturate at the top; the wide counter wraps 255 -> 0.
        drive(0, 1, 0, 1, 0, 9, 0); d8 = 8'd255; tick();
        drive(0, 0, 1, 1, 0, 9, 0);
        repeat (3) tick();
        check("sat_hold_hi", ib.q, 4'd9);
        drive(0, 0, 0, 1, 1, 0, 0); tick();
        check("clr_ovf_alone", ia.ovf, 1'b0);
        // Wrap/saturate at the bottom.
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0, 0); tick(); tick();
        check("sat_hold_lo", ib.q, 4'd0);
        // Load clamps and blocks counting.
        drive(0, 1, 1, 1, 0, 15, 0); tick();
        check("load_clamp", ia.q, 4'd9);
        drive(0, 1, 0, 1, 0, 4, 0); tick();
        check("load_in_range", ia.q, 4'd4);
        drive(0, 1, 0, 1, 0, 3, 5); tick();
        drive(0, 0, 1, 1, 0, 3, 5); tick(); tick();
        check("match_at_5", {ia.q, ia.match}, {4'd5, 1'b1});
        // clr_ovf loses against a same-cycle wrap.
        drive(0, 1, 0, 1, 0, 9, 0); tick();
        drive(0, 0, 1, 1, 1, 9, 0); tick();
        check("clr_vs_wrap", ia.ovf, 1'b1);
        drive(0, 0, 0, 1, 1, 0, 0); tick();

        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 15), $urandom_range(0, 15));
            if (!load) clr_ovf = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) d8 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) cmp8 = 8'($urandom_range(0, 255));
            tick();
        end

        drive(0, 0, 0, 1, 0, 0, 0);
        c_reset = 1'b0; c_cin = 1'b1; c_up = 1'b1; pulses = 0;
        repeat (100) tick();
        check("casc_hi_cout_once", pulses, 1);
        check("casc_back_to_00", {ihi.q, ilo.q}, 8'h00);
        for (int k = 0; k < 60; k++) begin
            c_cin = ($urandom_range(0, 3) != 0);
            c_up  = ($urandom_range(0, 2) != 0);
            tick();
        end
        c_reset = 1'b1; c_cin = 1'b1; tick();
        check("casc_reset_mid", {ihi.q, ilo.q}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
